uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 217, clk cycles per serial bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on posedge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: data  output  8  last correctly framed byte.
REQ-006 SHALL have port: valid  output  1  one-cycle pulse; data updated this cycle.
REQ-007 SHALL have port: frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs (2-cycle input latency).
REQ-010 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with a bit-timer counter of width $clog2(CLKS_PER_BIT).
REQ-011 IDLE: rxs low -> START, timer cleared.
REQ-012 START: at timer == (CLKS_PER_BIT-1)/2, rxs low -> DATA with timer cleared and bit index 0; rxs high -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: at timer == CLKS_PER_BIT-1, sample rxs into shift register LSB first and clear timer; after bit index 7 -> STOP.
REQ-014 STOP: at timer == CLKS_PER_BIT-1, rxs high -> load data, pulse valid the next cycle, go IDLE; rxs low -> pulse frame_err, keep data unchanged, go WAIT_IDLE.
REQ-015 WAIT_IDLE: stay until rxs high, then IDLE (break condition yields exactly one frame_err).
REQ-016 valid and frame_err SHALL never be high in the same cycle and SHALL each last exactly one cycle.
REQ-017 Back-to-back frames (start bit immediately following stop bit) SHALL be received without loss.
REQ-018 A start edge arriving during STOP SHALL not be lost: IDLE is re-entered within half a bit so the next START mid-sample still falls inside the start bit.

Reset
REQ-019 On rst: state IDLE, timer 0, bit index 0, shift register 0x00, data 0x00, valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release the receiver waits for a fresh falling edge.

Configuration
REQ-021 Macro UART_RX_PARITY_EN: defined -> frame carries an even-parity bit between bit 7 and stop, state PARITY added, output parity_err (1 bit, one-cycle pulse, in place of valid; data not updated); undefined -> 8N1, no PARITY state, no parity_err port.

Structure
REQ-022 Package uart_pkg SHALL hold the state enum type, DEFAULT_CLKS_PER_BIT = 217, and DATA_BITS = 8.
REQ-023 Synchronizer SHALL be a separate sub-module sync2 (1-bit, reset value parameterized, here 1).

Verification (CLKS_PER_BIT = 8 unless stated)
REQ-024 Send 0x55 8N1 -> valid exactly one cycle, data = 0x55, frame_err never high.
REQ-025 Drive rx low for 2 cycles then high -> no valid, no frame_err, busy returns low within 8 cycles.
REQ-026 Send 0xA3 with stop bit low, then 0x3C normal -> frame_err one pulse, data stays at the prior value through the bad frame, then data = 0x3C with valid.
REQ-027 Send 0x00 and 0xFF back-to-back with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-028 Assert rst during bit 4 of 0x81, release, send 0x42 -> no pulse for 0x81, valid with data = 0x42.
REQ-029 With UART_RX_PARITY_EN, send 0x07 with odd parity bit -> parity_err pulse, no valid; 0x07 with parity 1 -> valid, data = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART byte receiver.
//   state_e              receiver FSM states (PARITY present only when
//                        UART_RX_PARITY_EN is defined)
//   DEFAULT_CLKS_PER_BIT clk cycles per serial bit (25 MHz / 115200)
//   DATA_BITS            payload bits per frame
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
//   clk, rst  system clock, asynchronous active-high reset
//   d_i       asynchronous input
//   q_o       synchronized output (2-cycle latency)
// RESET_VAL sets the value both flops take in reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with mid-bit sampling.
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial line, idle high
//   data       last correctly framed byte
//   valid      one-cycle pulse, data updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever the receiver is not IDLE
//   parity_err one-cycle pulse on even-parity mismatch (UART_RX_PARITY_EN only)
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a PARITY state.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF   = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxs;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic           perr_q, perr_d;
  logic           pbad_q, pbad_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (timer_q == T_HALF) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          pbad_d  = (^shift_q) ^ rxs;
          state_d = STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit keeps a following start edge inside the
        // next START sampling window.
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx at CLKS_PER_BIT = 8.
// Frames push their expected outcome when driven; the per-cycle monitor
// pops and compares whenever the receiver pulses.
module tb_uart_byte_rx;

  localparam int unsigned CPB = 8;
  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cycles = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_any = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One cycle: advance to negedge and inspect the outputs.
  task automatic tick();
    int   kind;
    int   npulse;
    logic perr;
    exp_t e;
    @(negedge clk);
    cycles++;
    if (cycles > 50000) begin
      $display("FAIL timeout got %0d exp %0d", cycles, 50000);
      $fatal(1, "timeout");
    end
`ifdef UART_RX_PARITY_EN
    perr = parity_err;
`else
    perr = 1'b0;
`endif
    if (rst) begin
      model_data = 8'h00;
      prev_any   = 1'b0;
    end else begin
      npulse = int'(valid) + int'(frame_err) + int'(perr);
      kind   = valid ? K_VALID : frame_err ? K_FERR : perr ? K_PERR : K_NONE;
      if (npulse > 1) check_eq("pulse_excl", npulse, 1);
      if (npulse != 0) begin
        check_eq("pulse_width", prev_any, 0);
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", kind, K_NONE);
        end else begin
          e = sb.pop_front();
          check_eq("pulse_kind", kind, e.kind);
          if (e.kind == K_VALID) begin
            check_eq("rx_data", data, e.d);
            model_data = e.d;
          end else begin
            check_eq("data_hold", data, model_data);
          end
        end
      end
      prev_any = (npulse != 0);
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      rx = v;
    end
  endtask

  // abort_bit < 8 asserts reset half-way through that data bit.
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop, input int unsigned abort_bit);
    exp_t e;
    logic pbit;
    pbit = (^b) ^ par_flip;
    if (abort_bit >= 8) begin
      e.d    = b;
      e.kind = !stop ? K_FERR : par_flip ? K_PERR : K_VALID;
      sb.push_back(e);
    end
    drive_bit(1'b0, CPB);
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        drive_bit(b[i], CPB / 2);
        tick();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        return;
      end
      drive_bit(b[i], CPB);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit, CPB);
`else
    if (pbit === 1'bx) drive_bit(1'b1, 0);
`endif
    drive_bit(stop, CPB);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * 11 * CPB && sb.size() != 0; i++) tick();
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_busy", busy, 0);

    // Clean 8N1 byte
    send_frame(8'h55, 1'b0, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_55");

    // Short glitch must be rejected
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 8);
    tick();
    check_eq("glitch_busy", busy, 0);
    check_eq("glitch_sb", sb.size(), 0);

    // Bad stop bit, line idles, then a good byte
    send_frame(8'hA3, 1'b0, 1'b0, 99);
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h3C, 1'b0, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_3c");
    check_eq("data_3c", data, 8'h3C);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, 99);
    send_frame(8'hFF, 1'b0, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_b2b");
    check_eq("data_ff", data, 8'hFF);

    // Reset during bit 4 of 0x81 aborts silently and clears data
    send_frame(8'h81, 1'b0, 1'b1, 4);
    tick();
    check_eq("abort_data", data, 8'h00);
    check_eq("abort_busy", busy, 0);
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h42, 1'b0, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_42");
    check_eq("data_42", data, 8'h42);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_perr");
    check_eq("data_after_perr", data, 8'h42);
    send_frame(8'h07, 1'b0, 1'b1, 99);
    drive_bit(1'b1, CPB);
    drain("drain_par_ok");
    check_eq("data_07", data, 8'h07);
`endif

    drive_bit(1'b1, 2 * CPB);
    check_eq("final_sb", sb.size(), 0);
    check_eq("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
